// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the 5-stage MIPS core. Detects load-use,
// branch-operand and HI/LO (mult/div) occupancy hazards and drives the PC,
// IF/ID hold and ID/EX bubble controls. A small two-state tracker counts down
// the EX occupancy of one multi-cycle mult/div.
//
// Parameters
//   REG_AW     register-address width (default 5)
//   MD_CYCLES  mult/div occupancy in cycles, 1..255 (default 32)
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   rs_id, rt_id         source fields of the ID instruction
//   use_rs_id, use_rt_id ID instruction actually reads rs / rt
//   branch_id            ID instruction is a branch resolved in ID
//   md_use_id            ID instruction touches HI/LO or the md unit
//   regwr_ex, memrd_ex   EX instruction writes a register / is a load
//   wreg_ex              EX destination register
//   memrd_mem, wreg_mem  MEM instruction is a load / its destination
//   md_start_ex          a mult/div is valid in EX this cycle
//   stall_if             hold the PC
//   stall_id             hold the IF/ID register
//   flush_ex             clear ID/EX (insert bubble)
//   md_busy              HI/LO unit occupied (registered)
//   stall_cycles         (HAZ_PERF_CNT_EN only) saturating count of stall cycles
//
// Optional feature: define HAZ_PERF_CNT_EN to add the stall_cycles counter.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    input  logic              branch_id,
    input  logic              md_use_id,
    input  logic              regwr_ex,
    input  logic              memrd_ex,
    input  logic [REG_AW-1:0] wreg_ex,
    input  logic              memrd_mem,
    input  logic [REG_AW-1:0] wreg_mem,
    input  logic              md_start_ex,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_ex,
    output logic              md_busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int CW = $clog2(MD_CYCLES + 1);
    localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES);

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t     state, state_nxt;
    logic [CW-1:0] md_cnt, md_cnt_nxt;

    logic hit_ex, hit_mem;
    logic lw_stall, br_stall, md_stall, stall;

    // Source match against a destination; $0 is never a hazard source.
    function automatic logic hit(input logic [REG_AW-1:0] w,
                                 input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rt,
                                 input logic              urs,
                                 input logic              urt);
        return (w != '0) && ((urs && (rs == w)) || (urt && (rt == w)));
    endfunction

    assign hit_ex  = hit(wreg_ex,  rs_id, rt_id, use_rs_id, use_rt_id);
    assign hit_mem = hit(wreg_mem, rs_id, rt_id, use_rs_id, use_rt_id);

    assign lw_stall = memrd_ex & regwr_ex & hit_ex;
    // ALU results in MEM are forwarded to the ID comparator; only a load in
    // MEM (data not yet back) holds a branch.
    assign br_stall = branch_id & ((regwr_ex & hit_ex) | (memrd_mem & hit_mem));
    // A starting mult/div already occupies HI/LO for a dependant in ID.
    assign md_stall = md_use_id & (md_busy | md_start_ex);

    assign stall    = lw_stall | br_stall | md_stall;
    assign stall_if = stall & ~rst;
    assign stall_id = stall & ~rst;
    assign flush_ex = stall & ~rst;

    // md occupancy tracker: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // md occupancy tracker: next state. A start seen while BUSY (including the
    // final 1->0 cycle) is dropped; the ID-side stall prevents that in
    // well-formed code.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            MD_IDLE: begin
                if (md_start_ex) begin
                    md_cnt_nxt = MD_LOAD;
                    state_nxt  = MD_BUSY;
                end
            end
            MD_BUSY: begin
                md_cnt_nxt = md_cnt - CW'(1);
                if (md_cnt == CW'(1))
                    state_nxt = MD_IDLE;
            end
            default: begin
                state_nxt  = MD_IDLE;
                md_cnt_nxt = '0;
            end
        endcase
    end

    assign md_busy = (state == MD_BUSY);

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall_if && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int MD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs_id, rt_id, wreg_ex, wreg_mem;
    logic          use_rs_id, use_rt_id, branch_id, md_use_id;
    logic          regwr_ex, memrd_ex, memrd_mem, md_start_ex;
    logic          stall_if, stall_id, flush_ex, md_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   sc0;
`endif

    int errors = 0;
    int checks = 0;

    // model state: cycle number and the cycle in which the accepted md op started
    int cyc     = 0;
    int start_c = -1000;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(AW), .MD_CYCLES(MD)) dut (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .branch_id(branch_id), .md_use_id(md_use_id),
        .regwr_ex(regwr_ex), .memrd_ex(memrd_ex), .wreg_ex(wreg_ex),
        .memrd_mem(memrd_mem), .wreg_mem(wreg_mem),
        .md_start_ex(md_start_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_ex(flush_ex),
        .md_busy(md_busy)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    typedef struct {
        logic [AW-1:0] rs, rt;
        logic          urs, urt, br, mdu, rwx, mrx;
        logic [AW-1:0] wx;
        logic          mrm;
        logic [AW-1:0] wm;
        logic          st;
        logic          exp;
    } vec_t;

    vec_t vecs[13];

    // ---------------- reference model (from the hazard rules) ----------------
    function automatic bit m_reads(int w);
        return (w != 0) && ((use_rs_id && int'(rs_id) == w) || (use_rt_id && int'(rt_id) == w));
    endfunction

    function automatic bit m_busy();
        return !rst && (cyc > start_c) && (cyc <= start_c + MD);
    endfunction

    function automatic bit m_stall();
        bit s;
        s = 0;
        if (memrd_ex && regwr_ex && m_reads(int'(wreg_ex))) s = 1;
        if (branch_id && regwr_ex && m_reads(int'(wreg_ex))) s = 1;
        if (branch_id && memrd_mem && m_reads(int'(wreg_mem))) s = 1;
        if (md_use_id && (m_busy() || md_start_ex)) s = 1;
        return s && !rst;
    endfunction

    task automatic chk(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Called right after a negedge with inputs already applied: checks the
    // outputs, advances through the posedge, updates the model, and returns
    // at the next negedge.
    task automatic step(input string nm, input logic es, input logic eb);
        if (rst) start_c = -1000;
        #2;
        chk({nm, ".stall_if"}, stall_if, es);
        chk({nm, ".stall_id"}, stall_id, es);
        chk({nm, ".flush_ex"}, flush_ex, es);
        chk({nm, ".md_busy"},  md_busy,  eb);
        @(posedge clk);
        if (!rst && md_start_ex && !m_busy()) start_c = cyc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rs_id = '0; rt_id = '0; use_rs_id = 0; use_rt_id = 0;
        branch_id = 0; md_use_id = 0; regwr_ex = 0; memrd_ex = 0;
        wreg_ex = '0; memrd_mem = 0; wreg_mem = '0; md_start_ex = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs_id = v.rs; rt_id = v.rt; use_rs_id = v.urs; use_rt_id = v.urt;
        branch_id = v.br; md_use_id = v.mdu; regwr_ex = v.rwx; memrd_ex = v.mrx;
        wreg_ex = v.wx; memrd_mem = v.mrm; wreg_mem = v.wm; md_start_ex = v.st;
    endtask

    initial begin
        //               rs rt urs urt br mdu rwx mrx wx mrm wm st exp
        vecs[0]  = '{5'd8, 5'd0, 1, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0, 0, 1}; // load-use rs
        vecs[1]  = '{5'd8, 5'd0, 0, 0, 0, 0, 1, 1, 5'd8, 0, 5'd0, 0, 0}; // rs not read
        vecs[2]  = '{5'd0, 5'd0, 1, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 0, 0}; // $0 load
        vecs[3]  = '{5'd0, 5'd9, 0, 1, 1, 0, 1, 0, 5'd9, 0, 5'd0, 0, 1}; // br, ALU in EX
        vecs[4]  = '{5'd0, 5'd9, 0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd9, 0, 0}; // br, ALU in MEM
        vecs[5]  = '{5'd0, 5'd9, 0, 1, 1, 0, 0, 0, 5'd0, 1, 5'd9, 0, 1}; // br, load in MEM
        vecs[6]  = '{5'd0, 5'd9, 0, 1, 0, 0, 0, 0, 5'd0, 1, 5'd9, 0, 0}; // non-br, load MEM
        vecs[7]  = '{5'd0, 5'd5, 0, 1, 0, 0, 1, 1, 5'd5, 0, 5'd0, 0, 1}; // load-use rt
        vecs[8]  = '{5'd5, 5'd0, 1, 0, 0, 0, 0, 1, 5'd5, 0, 5'd0, 0, 0}; // load, no regwr
        vecs[9]  = '{5'd8, 5'd0, 1, 0, 0, 0, 1, 0, 5'd8, 0, 5'd0, 0, 0}; // ALU in EX
        vecs[10] = '{5'd0, 5'd0, 1, 1, 1, 0, 1, 0, 5'd0, 1, 5'd0, 0, 0}; // br on $0
        vecs[11] = '{5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 0}; // md idle
        vecs[12] = '{5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 1}; // md start

        // reset: outputs forced low even with a live hazard on the inputs
        idle_inputs();
        rst = 1;
        @(negedge clk);
        apply_vec(vecs[0]);
        step("reset_forced", 0, 0);
        idle_inputs();
        step("reset_idle", 0, 0);
        rst = 0;
        step("after_reset", 0, 0);

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            step($sformatf("vec%0d", i), vecs[i].exp, 0);
        end
        // the last vector started an md op; clear it with a reset
        idle_inputs();
        rst = 1;
        step("vec_reset", 0, 0);
        rst = 0;
        step("vec_release", 0, 0);

        // divide, MD=4: start in T, mflo in ID stalls T..T+4, busy T+1..T+4
`ifdef HAZ_PERF_CNT_EN
        sc0 = stall_cycles;
`endif
        for (int i = 0; i <= 6; i++) begin
            idle_inputs();
            md_use_id   = 1;
            md_start_ex = (i == 0);
            step($sformatf("div_t%0d", i), (i <= MD), (i >= 1 && i <= MD));
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (stall_cycles - sc0 != 32'd5) begin
            errors++;
            $display("FAIL perf_cnt: got %0d expected 5", stall_cycles - sc0);
        end
`endif

        // reset in the 2nd busy cycle
        idle_inputs();
        md_start_ex = 1;
        step("rmb_start", 0, 0);
        md_start_ex = 0;
        md_use_id = 1;
        step("rmb_busy1", 1, 1);
        rst = 1;
        step("rmb_rst", 0, 0);
        rst = 0;
        step("rmb_after", 0, 0);
        step("rmb_after2", 0, 0);

        // load-use lasts one cycle; branch on a load stalls two
        idle_inputs();
        rs_id = 5'd7; use_rs_id = 1; branch_id = 1;
        memrd_ex = 1; regwr_ex = 1; wreg_ex = 5'd7;
        step("brld_c1", 1, 0);
        memrd_ex = 0; regwr_ex = 0; wreg_ex = 5'd0;
        memrd_mem = 1; wreg_mem = 5'd7;
        step("brld_c2", 1, 0);
        memrd_mem = 0; wreg_mem = 5'd0;
        step("brld_c3", 0, 0);

        // randomized traffic against the model; small register range for hits
        for (int n = 0; n < 600; n++) begin
            rs_id       = AW'($urandom_range(0, 3));
            rt_id       = AW'($urandom_range(0, 3));
            wreg_ex     = AW'($urandom_range(0, 3));
            wreg_mem    = AW'($urandom_range(0, 3));
            use_rs_id   = 1'($urandom);
            use_rt_id   = 1'($urandom);
            branch_id   = 1'($urandom);
            md_use_id   = ($urandom_range(0, 3) == 0);
            regwr_ex    = 1'($urandom);
            memrd_ex    = 1'($urandom);
            memrd_mem   = 1'($urandom);
            md_start_ex = ($urandom_range(0, 5) == 0);
            rst         = ($urandom_range(0, 59) == 0);
            if (rst) start_c = -1000;
            step("rand", m_stall(), m_busy());
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
